// File: rtl/id_ex_hazard_reg.sv
// ID/EX pipeline register with load-use hazard detection.
// Captures decoded operands and control from ID. It inserts a bubble and
// raises stall when the instruction in ID reads the destination of a load
// that is now in EX. A taken branch squashes ID, and a MEM stall freezes the
// register. reg_write is cleared for rd == x0, so the forwarding unit never
// matches x0.
module id_ex_hazard_reg #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             if_id_valid,
    input  logic [XLEN-1:0]  if_id_pc,
    input  logic [XLEN-1:0]  if_id_imm,
    input  logic [4:0]       if_id_rs1_idx,
    input  logic [4:0]       if_id_rs2_idx,
    input  logic             if_id_rs1_used,
    input  logic             if_id_rs2_used,
    input  logic [4:0]       if_id_rd_idx,
    input  logic             if_id_reg_write,
    input  logic             if_id_mem_read,
    input  logic             if_id_mem_write,
    input  logic [XLEN-1:0]  rs1_data,
    input  logic [XLEN-1:0]  rs2_data,
    input  logic             ex_flush,
    input  logic             mem_stall,
    output logic             id_ex_valid,
    output logic [XLEN-1:0]  id_ex_pc,
    output logic [XLEN-1:0]  id_ex_imm,
    output logic [XLEN-1:0]  id_ex_rs1_data,
    output logic [XLEN-1:0]  id_ex_rs2_data,
    output logic [4:0]       id_ex_rs1_idx,
    output logic [4:0]       id_ex_rs2_idx,
    output logic [4:0]       id_ex_rd_idx,
    output logic             id_ex_reg_write,
    output logic             id_ex_mem_read,
    output logic             id_ex_mem_write,
    output logic             stall,
    output logic [CNT_W-1:0] load_use_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic load_in_ex;
    logic rs1_hit;
    logic rs2_hit;
    logic hazard;

    // Load-use detection: a live load in EX writes a register that ID reads.
    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path can leave it unassigned and infer a latch.
        load_in_ex = 1'b0;
        rs1_hit    = 1'b0;
        rs2_hit    = 1'b0;
        hazard     = 1'b0;

        load_in_ex = id_ex_valid & id_ex_mem_read & (id_ex_rd_idx != 5'd0);
        rs1_hit    = if_id_rs1_used & (if_id_rs1_idx == id_ex_rd_idx);
        rs2_hit    = if_id_rs2_used & (if_id_rs2_idx == id_ex_rd_idx);
        hazard     = load_in_ex & if_id_valid & (rs1_hit | rs2_hit);
    end

    // A taken branch suppresses the stall because the dependent instruction is squashed anyway.
    assign stall = mem_stall | (hazard & ~ex_flush);

    // Pipeline register: reset, then hold on a MEM stall, then bubble on a flush or hazard, otherwise capture.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
        if (!rst_n) begin
            id_ex_valid     <= 1'b0;
            id_ex_pc        <= '0;
            id_ex_imm       <= '0;
            id_ex_rs1_data  <= '0;
            id_ex_rs2_data  <= '0;
            id_ex_rs1_idx   <= 5'd0;
            id_ex_rs2_idx   <= 5'd0;
            id_ex_rd_idx    <= 5'd0;
            id_ex_reg_write <= 1'b0;
            id_ex_mem_read  <= 1'b0;
            id_ex_mem_write <= 1'b0;
            load_use_cnt    <= '0;
        end else if (!mem_stall) begin
            if (ex_flush || hazard) begin
                // Bubble: kill control and indices. pc, imm and data keep their
                // old values so that the datapath does not toggle.
                id_ex_valid     <= 1'b0;
                id_ex_rs1_idx   <= 5'd0;
                id_ex_rs2_idx   <= 5'd0;
                id_ex_rd_idx    <= 5'd0;
                id_ex_reg_write <= 1'b0;
                id_ex_mem_read  <= 1'b0;
                id_ex_mem_write <= 1'b0;
                // Only a real load-use bubble counts. A flush that hides a hazard does not count.
                if (!ex_flush && (load_use_cnt != CNT_MAX)) begin
                    load_use_cnt <= load_use_cnt + CNT_ONE;
                end
            end else begin
                id_ex_valid     <= if_id_valid;
                id_ex_pc        <= if_id_pc;
                id_ex_imm       <= if_id_imm;
                id_ex_rs1_data  <= rs1_data;
                id_ex_rs2_data  <= rs2_data;
                id_ex_rs1_idx   <= if_id_rs1_idx;
                id_ex_rs2_idx   <= if_id_rs2_idx;
                id_ex_rd_idx    <= if_id_rd_idx;
                id_ex_reg_write <= if_id_reg_write & (if_id_rd_idx != 5'd0) & if_id_valid;
                id_ex_mem_read  <= if_id_mem_read & if_id_valid;
                id_ex_mem_write <= if_id_mem_write & if_id_valid;
            end
        end
    end

endmodule

// File: tb/tb_id_ex_hazard_reg.sv
// Directed scoreboard bench for id_ex_hazard_reg.
// The driver applies one vector per cycle, just after the rising edge. With
// each vector it queues the outputs expected at the falling edge of that
// cycle. Those are the registered state left by the previous vector, plus the
// combinational stall for this vector. The monitor pops one entry at each
// falling edge and compares it.
module tb_id_ex_hazard_reg;

    localparam int XLEN  = 32;
    localparam int CNT_W = 2;

    typedef struct {
        logic        rst_n;
        logic        valid;
        logic [31:0] pc;
        logic [31:0] imm;
        logic [31:0] d1;
        logic [31:0] d2;
        logic [4:0]  rs1;
        logic        u1;
        logic [4:0]  rs2;
        logic        u2;
        logic [4:0]  rd;
        logic        rw;
        logic        mr;
        logic        mw;
        logic        flush;
        logic        mstall;
    } in_t;

    typedef struct {
        string       name;
        logic        stall;
        logic        valid;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic        rw;
        logic        mr;
        logic        mw;
        logic [31:0] pc;
        logic [31:0] imm;
        logic [31:0] d1;
        logic [31:0] d2;
        logic [1:0]  cnt;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             if_id_valid;
    logic [XLEN-1:0]  if_id_pc;
    logic [XLEN-1:0]  if_id_imm;
    logic [4:0]       if_id_rs1_idx;
    logic [4:0]       if_id_rs2_idx;
    logic             if_id_rs1_used;
    logic             if_id_rs2_used;
    logic [4:0]       if_id_rd_idx;
    logic             if_id_reg_write;
    logic             if_id_mem_read;
    logic             if_id_mem_write;
    logic [XLEN-1:0]  rs1_data;
    logic [XLEN-1:0]  rs2_data;
    logic             ex_flush;
    logic             mem_stall;
    logic             id_ex_valid;
    logic [XLEN-1:0]  id_ex_pc;
    logic [XLEN-1:0]  id_ex_imm;
    logic [XLEN-1:0]  id_ex_rs1_data;
    logic [XLEN-1:0]  id_ex_rs2_data;
    logic [4:0]       id_ex_rs1_idx;
    logic [4:0]       id_ex_rs2_idx;
    logic [4:0]       id_ex_rd_idx;
    logic             id_ex_reg_write;
    logic             id_ex_mem_read;
    logic             id_ex_mem_write;
    logic             stall;
    logic [CNT_W-1:0] load_use_cnt;

    int   n_checks = 0;
    int   n_errors = 0;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    id_ex_hazard_reg #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .if_id_valid     (if_id_valid),
        .if_id_pc        (if_id_pc),
        .if_id_imm       (if_id_imm),
        .if_id_rs1_idx   (if_id_rs1_idx),
        .if_id_rs2_idx   (if_id_rs2_idx),
        .if_id_rs1_used  (if_id_rs1_used),
        .if_id_rs2_used  (if_id_rs2_used),
        .if_id_rd_idx    (if_id_rd_idx),
        .if_id_reg_write (if_id_reg_write),
        .if_id_mem_read  (if_id_mem_read),
        .if_id_mem_write (if_id_mem_write),
        .rs1_data        (rs1_data),
        .rs2_data        (rs2_data),
        .ex_flush        (ex_flush),
        .mem_stall       (mem_stall),
        .id_ex_valid     (id_ex_valid),
        .id_ex_pc        (id_ex_pc),
        .id_ex_imm       (id_ex_imm),
        .id_ex_rs1_data  (id_ex_rs1_data),
        .id_ex_rs2_data  (id_ex_rs2_data),
        .id_ex_rs1_idx   (id_ex_rs1_idx),
        .id_ex_rs2_idx   (id_ex_rs2_idx),
        .id_ex_rd_idx    (id_ex_rd_idx),
        .id_ex_reg_write (id_ex_reg_write),
        .id_ex_mem_read  (id_ex_mem_read),
        .id_ex_mem_write (id_ex_mem_write),
        .stall           (stall),
        .load_use_cnt    (load_use_cnt)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // Operand data follows a fixed rule from the pc, so held values can be checked in bubbles.
    function automatic in_t ins(logic [31:0] pc, logic [4:0] rs1, logic u1, logic [4:0] rs2,
                                logic u2, logic [4:0] rd, logic rw, logic mr, logic mw);
        in_t i;
        i.rst_n = 1'b1; i.valid = 1'b1; i.pc = pc;
        i.imm = pc << 1; i.d1 = pc << 2; i.d2 = pc << 3;
        i.rs1 = rs1; i.u1 = u1; i.rs2 = rs2; i.u2 = u2; i.rd = rd;
        i.rw = rw; i.mr = mr; i.mw = mw; i.flush = 1'b0; i.mstall = 1'b0;
        return i;
    endfunction

    function automatic in_t ld(logic [31:0] pc, logic [4:0] rs1, logic [4:0] rd);
        return ins(pc, rs1, 1'b1, 5'd0, 1'b0, rd, 1'b1, 1'b1, 1'b0);
    endfunction

    function automatic in_t alu(logic [31:0] pc, logic [4:0] rs1, logic [4:0] rs2, logic [4:0] rd);
        return ins(pc, rs1, 1'b1, rs2, 1'b1, rd, 1'b1, 1'b0, 1'b0);
    endfunction

    function automatic in_t nop();
        in_t i;
        i = ins(32'd0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        i.valid = 1'b0;
        return i;
    endfunction

    function automatic in_t rnd_in();
        in_t i;
        i.rst_n = 1'b0; i.valid = 1'($urandom); i.pc = $urandom;
        i.imm = $urandom; i.d1 = $urandom; i.d2 = $urandom;
        i.rs1 = 5'($urandom); i.u1 = 1'($urandom); i.rs2 = 5'($urandom); i.u2 = 1'($urandom);
        i.rd = 5'($urandom); i.rw = 1'($urandom); i.mr = 1'($urandom); i.mw = 1'($urandom);
        i.flush = 1'($urandom); i.mstall = 1'($urandom);
        return i;
    endfunction

    function automatic exp_t ex(string name, logic st, logic v, logic [4:0] rs1, logic [4:0] rs2,
                                logic [4:0] rd, logic rw, logic mr, logic mw, logic [31:0] pc,
                                logic [1:0] cnt);
        exp_t e;
        e.name = name; e.stall = st; e.valid = v; e.rs1 = rs1; e.rs2 = rs2; e.rd = rd;
        e.rw = rw; e.mr = mr; e.mw = mw; e.pc = pc;
        e.imm = pc << 1; e.d1 = pc << 2; e.d2 = pc << 3; e.cnt = cnt;
        return e;
    endfunction

    function automatic exp_t zero(string name, logic st, logic [1:0] cnt);
        return ex(name, st, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 32'd0, cnt);
    endfunction

    function automatic exp_t bub(string name, logic st, logic [31:0] pc, logic [1:0] cnt);
        return ex(name, st, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, pc, cnt);
    endfunction

    task automatic apply(input in_t i);
        rst_n           = i.rst_n;
        if_id_valid     = i.valid;
        if_id_pc        = i.pc;
        if_id_imm       = i.imm;
        rs1_data        = i.d1;
        rs2_data        = i.d2;
        if_id_rs1_idx   = i.rs1;
        if_id_rs1_used  = i.u1;
        if_id_rs2_idx   = i.rs2;
        if_id_rs2_used  = i.u2;
        if_id_rd_idx    = i.rd;
        if_id_reg_write = i.rw;
        if_id_mem_read  = i.mr;
        if_id_mem_write = i.mw;
        ex_flush        = i.flush;
        mem_stall       = i.mstall;
    endtask

    task automatic cyc(input in_t i, input exp_t e);
        @(posedge clk);
        #1;
        apply(i);
        exp_q.push_back(e);
    endtask

    // Monitor: at every falling edge, compare the DUT outputs against the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check({e.name, ".stall"},     32'(stall),           32'(e.stall));
                check({e.name, ".valid"},     32'(id_ex_valid),     32'(e.valid));
                check({e.name, ".rs1_idx"},   32'(id_ex_rs1_idx),   32'(e.rs1));
                check({e.name, ".rs2_idx"},   32'(id_ex_rs2_idx),   32'(e.rs2));
                check({e.name, ".rd_idx"},    32'(id_ex_rd_idx),    32'(e.rd));
                check({e.name, ".reg_write"}, 32'(id_ex_reg_write), 32'(e.rw));
                check({e.name, ".mem_read"},  32'(id_ex_mem_read),  32'(e.mr));
                check({e.name, ".mem_write"}, 32'(id_ex_mem_write), 32'(e.mw));
                check({e.name, ".pc"},        id_ex_pc,             e.pc);
                check({e.name, ".imm"},       id_ex_imm,            e.imm);
                check({e.name, ".rs1_data"},  id_ex_rs1_data,       e.d1);
                check({e.name, ".rs2_data"},  id_ex_rs2_data,       e.d2);
                check({e.name, ".cnt"},       32'(load_use_cnt),    32'(e.cnt));
            end
        end
    end

    // Watchdog: the bench never hangs.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    // Driver: directed vectors with hand-derived expectations.
    initial begin
        in_t i;
        apply(nop());
        rst_n = 1'b0;

        // Reset with random inputs, and reset wins over mem_stall and flush.
        i = rnd_in(); cyc(i, zero("rst0", i.mstall, 2'd0));
        i = rnd_in(); cyc(i, zero("rst1", i.mstall, 2'd0));
        cyc(nop(), zero("rst2", 1'b0, 2'd0));

        // lw x5, then add x6,x5,x1: one stall cycle, one bubble, then capture.
        cyc(ld(32'h100, 5'd2, 5'd5),         zero("lu_pre", 1'b0, 2'd0));
        cyc(alu(32'h104, 5'd5, 5'd1, 5'd6),  ex("lu_haz", 1'b1, 1'b1, 5'd2, 5'd0, 5'd5, 1'b1, 1'b1, 1'b0, 32'h100, 2'd0));
        cyc(alu(32'h104, 5'd5, 5'd1, 5'd6),  bub("lu_bub", 1'b0, 32'h100, 2'd1));
        cyc(nop(),                           ex("lu_cap", 1'b0, 1'b1, 5'd5, 5'd1, 5'd6, 1'b1, 1'b0, 1'b0, 32'h104, 2'd1));

        // x0: a load to x0 causes no hazard, and reg_write is dropped for rd = 0.
        cyc(ld(32'h200, 5'd3, 5'd0),         zero("x0_pre", 1'b0, 2'd1));
        cyc(alu(32'h204, 5'd0, 5'd1, 5'd6),  ex("x0_ld", 1'b0, 1'b1, 5'd3, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 32'h200, 2'd1));
        cyc(ins(32'h208, 5'd1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0),
                                             ex("x0_add", 1'b0, 1'b1, 5'd0, 5'd1, 5'd6, 1'b1, 1'b0, 1'b0, 32'h204, 2'd1));
        cyc(nop(),                           ex("x0_rw", 1'b0, 1'b1, 5'd1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 32'h208, 2'd1));

        // A flush takes priority over a hazard: no stall, a bubble, and the counter is unchanged.
        cyc(ld(32'h300, 5'd2, 5'd7),         zero("fl_pre", 1'b0, 2'd1));
        i = ins(32'h304, 5'd2, 1'b1, 5'd7, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1); i.flush = 1'b1;
        cyc(i,                               ex("fl_haz", 1'b0, 1'b1, 5'd2, 5'd0, 5'd7, 1'b1, 1'b1, 1'b0, 32'h300, 2'd1));
        cyc(nop(),                           bub("fl_bub", 1'b0, 32'h300, 2'd1));

        // Unused source fields never hazard. A hazard on rs2 alone does.
        cyc(ld(32'h400, 5'd2, 5'd8),         zero("rs_pre", 1'b0, 2'd1));
        cyc(ins(32'h404, 5'd8, 1'b0, 5'd8, 1'b0, 5'd9, 1'b1, 1'b0, 1'b0),
                                             ex("rs_unused", 1'b0, 1'b1, 5'd2, 5'd0, 5'd8, 1'b1, 1'b1, 1'b0, 32'h400, 2'd1));
        cyc(ld(32'h408, 5'd1, 5'd10),        ex("rs_ld", 1'b0, 1'b1, 5'd8, 5'd8, 5'd9, 1'b1, 1'b0, 1'b0, 32'h404, 2'd1));
        i = ins(32'h40c, 5'd1, 1'b1, 5'd10, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1);
        cyc(i,                               ex("rs2_haz", 1'b1, 1'b1, 5'd1, 5'd0, 5'd10, 1'b1, 1'b1, 1'b0, 32'h408, 2'd1));
        cyc(i,                               bub("rs2_bub", 1'b0, 32'h408, 2'd2));
        cyc(nop(),                           ex("rs2_cap", 1'b0, 1'b1, 5'd1, 5'd10, 5'd0, 1'b0, 1'b0, 1'b1, 32'h40c, 2'd2));

        // mem_stall for three cycles while the ID inputs change: the register holds.
        cyc(alu(32'h500, 5'd11, 5'd12, 5'd13), zero("ms_pre", 1'b0, 2'd2));
        i = alu(32'h504, 5'd14, 5'd15, 5'd16); i.mstall = 1'b1;
        cyc(i,                               ex("ms_a", 1'b1, 1'b1, 5'd11, 5'd12, 5'd13, 1'b1, 1'b0, 1'b0, 32'h500, 2'd2));
        i = ld(32'h508, 5'd17, 5'd19); i.rs2 = 5'd18; i.u2 = 1'b1; i.mstall = 1'b1;
        cyc(i,                               ex("ms_h1", 1'b1, 1'b1, 5'd11, 5'd12, 5'd13, 1'b1, 1'b0, 1'b0, 32'h500, 2'd2));
        i = ins(32'h50c, 5'd20, 1'b1, 5'd0, 1'b0, 5'd21, 1'b0, 1'b0, 1'b1); i.mstall = 1'b1;
        cyc(i,                               ex("ms_h2", 1'b1, 1'b1, 5'd11, 5'd12, 5'd13, 1'b1, 1'b0, 1'b0, 32'h500, 2'd2));
        i.mstall = 1'b0;
        cyc(i,                               ex("ms_h3", 1'b0, 1'b1, 5'd11, 5'd12, 5'd13, 1'b1, 1'b0, 1'b0, 32'h500, 2'd2));
        cyc(nop(),                           ex("ms_cap", 1'b0, 1'b1, 5'd20, 5'd0, 5'd21, 1'b0, 1'b0, 1'b1, 32'h50c, 2'd2));

        // mem_stall on top of a hazard: hold, and do not count until the bubble is inserted.
        cyc(ld(32'h600, 5'd1, 5'd5),         zero("mh_pre", 1'b0, 2'd2));
        i = alu(32'h604, 5'd5, 5'd5, 5'd6); i.mstall = 1'b1;
        cyc(i,                               ex("mh_ms", 1'b1, 1'b1, 5'd1, 5'd0, 5'd5, 1'b1, 1'b1, 1'b0, 32'h600, 2'd2));
        i.mstall = 1'b0;
        cyc(i,                               ex("mh_haz", 1'b1, 1'b1, 5'd1, 5'd0, 5'd5, 1'b1, 1'b1, 1'b0, 32'h600, 2'd2));
        cyc(i,                               bub("mh_bub", 1'b0, 32'h600, 2'd3));
        cyc(nop(),                           ex("mh_cap", 1'b0, 1'b1, 5'd5, 5'd5, 5'd6, 1'b1, 1'b0, 1'b0, 32'h604, 2'd3));

        // Fourth and fifth load-use events: the 2-bit counter saturates at 3.
        cyc(ld(32'h700, 5'd1, 5'd5),         zero("sat_pre", 1'b0, 2'd3));
        cyc(alu(32'h704, 5'd5, 5'd1, 5'd6),  ex("sat_haz4", 1'b1, 1'b1, 5'd1, 5'd0, 5'd5, 1'b1, 1'b1, 1'b0, 32'h700, 2'd3));
        cyc(alu(32'h704, 5'd5, 5'd1, 5'd6),  bub("sat_bub4", 1'b0, 32'h700, 2'd3));
        cyc(ld(32'h708, 5'd6, 5'd5),         ex("sat_cap4", 1'b0, 1'b1, 5'd5, 5'd1, 5'd6, 1'b1, 1'b0, 1'b0, 32'h704, 2'd3));
        cyc(alu(32'h70c, 5'd1, 5'd5, 5'd6),  ex("sat_haz5", 1'b1, 1'b1, 5'd6, 5'd0, 5'd5, 1'b1, 1'b1, 1'b0, 32'h708, 2'd3));
        cyc(alu(32'h70c, 5'd1, 5'd5, 5'd6),  bub("sat_bub5", 1'b0, 32'h708, 2'd3));
        cyc(nop(),                           ex("sat_cap5", 1'b0, 1'b1, 5'd1, 5'd5, 5'd6, 1'b1, 1'b0, 1'b0, 32'h70c, 2'd3));

        // Reset asserted while stalled: the next edge clears everything, including the counter.
        cyc(ld(32'h800, 5'd1, 5'd5),         zero("rm_pre", 1'b0, 2'd3));
        i = ins(32'h804, 5'd5, 1'b1, 5'd0, 1'b0, 5'd6, 1'b1, 1'b0, 1'b0); i.rst_n = 1'b0;
        cyc(i,                               ex("rm_haz", 1'b1, 1'b1, 5'd1, 5'd0, 5'd5, 1'b1, 1'b1, 1'b0, 32'h800, 2'd3));
        cyc(i,                               zero("rm_clr", 1'b0, 2'd0));
        i.rst_n = 1'b1;
        cyc(i,                               zero("rm_hold", 1'b0, 2'd0));
        cyc(nop(),                           ex("rm_cap", 1'b0, 1'b1, 5'd5, 5'd0, 5'd6, 1'b1, 1'b0, 1'b0, 32'h804, 2'd0));
        cyc(nop(),                           zero("end", 1'b0, 2'd0));

        // Let the monitor drain the queue, then confirm that nothing is left unchecked.
        repeat (3) @(negedge clk);
        #1;
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
